// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream writer for the big-endian instruction memory.
// Optional checksum stage enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]        SYNC_BYTE = 8'hA5
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_FINISH
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_FINISH;
`endif

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [17:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [7:0]        wd_q, wd_d;
    logic              hold_q, hold_d;
    logic [15:0]       words_q, words_d;
    logic              acc;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              err_q, err_d;
`endif

    // The only non-accepting state is the single FINISH cycle.
    assign in_ready = (state_q != S_FINISH);
    assign acc      = in_valid && in_ready;

    assign im_we        = we_q;
    assign im_addr      = wa_q;
    assign im_wdata     = wd_q;
    assign cpu_hold     = hold_q;
    assign words_loaded = words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Frame parser: next state, write request and bookkeeping.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        hold_d  = hold_q;
        words_d = words_q;
        done    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            S_SYNC: begin
                if (acc && in_data == SYNC_BYTE) begin
                    state_d = S_LEN_HI;
                    hold_d  = 1'b1;
                    cnt_d   = '0;
                    addr_d  = BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (acc) begin
                    len_d[15:8] = in_data;
                    state_d     = S_LEN_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d      = csum_q ^ in_data;
`endif
                end
            end
            S_LEN_LO: begin
                if (acc) begin
                    len_d[7:0] = in_data;
                    if ({len_q[15:8], in_data} == 16'd0)
                        state_d = S_TAIL;
                    else
                        state_d = S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_data;
`endif
                end
            end
            S_DATA: begin
                if (acc) begin
                    we_d   = 1'b1;
                    wa_d   = addr_q;
                    wd_d   = in_data;
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 18'd1;
                    if (cnt_q + 18'd1 == {len_q, 2'b00})
                        state_d = S_TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (acc) begin
                    if (in_data == csum_q) begin
                        state_d = S_FINISH;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_SYNC;
                    end
                end
            end
`endif
            S_FINISH: begin
                done    = 1'b1;
                hold_d  = 1'b0;
                words_d = len_q;
                state_d = S_SYNC;
            end
            default: state_d = S_SYNC;
        endcase
    end

    // State and datapath registers; reset leaves memory contents alone.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_SYNC;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= BASE_ADDR;
            we_q    <= 1'b0;
            wa_q    <= BASE_ADDR;
            wd_q    <= '0;
            hold_q  <= 1'b1;
            words_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            hold_q  <= hold_d;
            words_q <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the CPU's instruction-memory read port.
- Receives a framed byte stream over a valid/ready handshake and writes the bytes into the byte-addressed, big-endian instruction memory.
- Holds the CPU (cpu_hold) from reset until a complete program frame has been written.
- Sits beside the CPU top; cpu_hold gates the CPU's Reset/PCWre path.

Parameters:
- ADDR_W, 8, width of the instruction-memory byte address.
- BASE_ADDR, 0, byte address of the first byte written in each frame.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- im_we  output  1  instruction-memory byte write enable.
- im_addr  output  ADDR_W  write byte address.
- im_wdata  output  8  write byte.
- cpu_hold  output  1  1 = CPU must be held in reset.
- done  output  1  one-cycle pulse: frame fully loaded.
- err  output  1  one-cycle pulse: frame rejected (checksum feature only).
- words_loaded  output  16  word count of the last completed frame.

Behaviour:
- Handshake and acceptance:
  - A byte is accepted when in_valid && in_ready on a rising CLK edge.
  - in_ready = 1 in states SYNC, LEN_HI, LEN_LO, DATA, CSUM; 0 in FINISH.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO (16-bit word count N), 4*N data bytes, then a CSUM byte only if the feature is enabled.
- States and transitions:
  - SYNC: accepted byte == SYNC_BYTE -> LEN_HI, cpu_hold <= 1, byte counter cleared, address <= BASE_ADDR. Any other byte is discarded; stay in SYNC.
  - LEN_HI: latch high byte -> LEN_LO.
  - LEN_LO: latch low byte. N == 0 -> FINISH (or CSUM when enabled). Otherwise -> DATA.
  - DATA: each accepted byte is written. After byte number 4*N is accepted -> FINISH (or CSUM).
  - FINISH: one cycle. done = 1, cpu_hold <= 0, words_loaded <= N -> SYNC.
- Write timing:
  - Registered; one cycle after a data byte is accepted: im_we = 1, im_addr = current address, im_wdata = that byte. The address then increments by 1.
  - im_we is 0 in every other cycle.
  - Byte order within a word is big-endian: first byte goes to the lowest address (bits 31:24).
- Address wrap: the address wraps modulo 2^ADDR_W with no error. The byte counter is 18 bits, so N = 65535 is legal.
- Gaps: in_valid low mid-frame stalls with no timeout; state and address are held.
- Reset (including mid-frame):
  - Next state SYNC, cpu_hold = 1, im_we = 0, done = 0, err = 0, words_loaded = 0, address = BASE_ADDR.
  - Bytes already written stay in memory.
- cpu_hold stays 1 after reset until the first FINISH. It reasserts on acceptance of any later SYNC_BYTE.
- A SYNC_BYTE value inside LEN or DATA is ordinary data.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro:
  - After LEN_LO (N == 0) or the last data byte, go to CSUM and accept one byte.
  - The byte is compared with the XOR of LEN_HI, LEN_LO and all data bytes.
  - Match -> FINISH.
  - Mismatch -> err = 1 for one cycle, cpu_hold stays 1, words_loaded unchanged -> SYNC. No rollback of memory writes.
- Without the macro: no CSUM state and err is tied to 0.

Test Plan:
- Reset, then idle 10 cycles -> cpu_hold = 1, im_we = 0, in_ready = 1, done = 0.
- Send 11, A5, 00, 01, DE, AD, BE, EF back-to-back -> 11 discarded; writes (0,DE), (1,AD), (2,BE), (3,EF) on consecutive cycles; done pulse; cpu_hold 1 -> 0; words_loaded = 1.
- Same frame with in_valid toggling every other cycle -> identical writes, only spaced out; no extra im_we.
- Send A5, 00, 00 -> no writes, done pulse, words_loaded = 0.
- Assert Reset after the 2nd data byte, then send a full frame -> writes restart at address 0; cpu_hold high until the new done.
- With IMEM_LOADER_CHECKSUM_EN: send A5, 00, 01, 01, 02, 03, 04, then checksum 05 -> done pulse. Repeat with checksum 06 -> err pulse and cpu_hold remains 1.
